// File: rtl/gray_cdc_pkg.sv
// Shared definitions for the Gray-code CDC receive endpoint.
//   - Default parameter values for counter width, channel count and
//     synchroniser depth.
//   - g2b: Gray-to-binary conversion.
//   - multi_bit: reports whether two or more bits of a word are set.
// The functions work on a fixed-width word (word_t). Callers zero-extend
// narrower values into it and truncate the result back. Zero-extension is
// harmless for both functions:
//   - zero upper Gray bits convert to zero upper binary bits;
//   - zero bits never add to a population count.
package gray_cdc_pkg;

  localparam int K_DEFAULT      = 8;
  localparam int C_DEFAULT      = 4;
  localparam int STAGES_DEFAULT = 2;

  // Widest counter supported per channel.
  localparam int MAX_W = 64;

  typedef logic [MAX_W-1:0] word_t;

  // The top bit passes through unchanged. Each lower binary bit is the XOR
  // of all Gray bits at or above it. That equals the binary bit one
  // position up, XORed with this position's Gray bit.
  function automatic word_t g2b(input word_t g);
    word_t b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Clearing the lowest set bit leaves something only if a second bit was
  // set.
  function automatic logic multi_bit(input word_t x);
    return (x & (x - word_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/gray_cdc_chan.sv
// One receive channel of the Gray-code CDC endpoint.
//   clk, rst   receive clock and asynchronous active-low reset
//   gray       asynchronous K-bit Gray word from the source domain
//   load       asynchronous load toggle; each level change marks a new word
//   warm_done  shared flag from the top. It is high once the synchronisers
//              hold post-reset data.
//   err_clr    synchronous clear of the sticky error flag
//   bin        last captured value, in binary
//   delta      bin minus the previously captured value, modulo 2^K
//   valid      one-cycle pulse per capture
//   err        sticky flag: a synchronised Gray step changed two or more bits
module gray_cdc_chan
  import gray_cdc_pkg::*;
#(
  parameter int K      = K_DEFAULT,
  parameter int STAGES = STAGES_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [K-1:0] gray,
  input  logic         load,
  input  logic         warm_done,
  input  logic         err_clr,
  output logic [K-1:0] bin,
  output logic [K-1:0] delta,
  output logic         valid,
  output logic         err
);

  // Synchroniser chains. Index 0 samples the asynchronous input.
  logic [K-1:0]      gray_sync [STAGES];
  logic [STAGES-1:0] tog_sync;

  logic [K-1:0] s_gray;
  logic         s_tog;
  logic         tog_d;
  logic [K-1:0] g_prev;

  logic         change;
  logic         capture;
  logic         violation;
  logic [K-1:0] bin_next;

  assign s_gray = gray_sync[STAGES-1];
  assign s_tog  = tog_sync[STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the synchroniser arrays are reset on purpose. A stale toggle
      // left in the chain would otherwise turn into a spurious capture
      // after reset. Plain storage arrays would normally be left unreset.
      for (int i = 0; i < STAGES; i++) begin
        gray_sync[i] <= '0;
      end
      tog_sync <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the
      // pre-edge value of its neighbour. That is what makes this a shift
      // chain rather than a single flop.
      gray_sync[0] <= gray;
      for (int i = 1; i < STAGES; i++) begin
        gray_sync[i] <= gray_sync[i-1];
      end
      tog_sync <= {tog_sync[STAGES-2:0], load};
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a value before any condition
    // is evaluated, so no path leaves one unassigned and no latch appears.
    change    = 1'b0;
    capture   = 1'b0;
    violation = 1'b0;
    bin_next  = K'(g2b(word_t'(s_gray)));

    change = s_tog ^ tog_d;
    // Until warm-up ends, edges are tracked but ignored. This absorbs the
    // level a source toggle already held when reset was released.
    capture   = warm_done & change;
    violation = warm_done & multi_bit(word_t'(s_gray ^ g_prev));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tog_d  <= 1'b0;
      g_prev <= '0;
      bin    <= '0;
      delta  <= '0;
      valid  <= 1'b0;
      err    <= 1'b0;
    end else begin
      // tog_d and g_prev track every cycle, warm-up included. The first
      // post-warm-up comparison therefore sees settled neighbours.
      tog_d  <= s_tog;
      g_prev <= s_gray;
      valid  <= capture;
      if (capture) begin
        bin   <= bin_next;
        delta <= bin_next - bin;   // K-bit subtraction wraps naturally
      end
      // A new violation outranks a clear arriving on the same edge.
      if (violation) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gray_cdc_rx.sv
// Multi-channel receive endpoint for Gray-coded counters crossing into the
// clk domain.
//   clk        receive-domain clock
//   rst        asynchronous active-low reset
//   gray_in    C asynchronous Gray words; channel c at [c*K +: K]
//   load_in    C asynchronous load toggles
//   err_clr    C synchronous clears of err_out
//   bin_out    C last captured values, binary
//   delta_out  C capture-to-capture differences, modulo 2^K
//   valid_out  C one-cycle capture pulses
//   err_out    C sticky Gray-violation flags
// This level holds only the shared warm-up counter and the port slicing.
// Each channel is an independent gray_cdc_chan.
module gray_cdc_rx
  import gray_cdc_pkg::*;
#(
  parameter int K      = K_DEFAULT,
  parameter int C      = C_DEFAULT,
  parameter int STAGES = STAGES_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [C*K-1:0] gray_in,
  input  logic [C-1:0]   load_in,
  input  logic [C-1:0]   err_clr,
  output logic [C*K-1:0] bin_out,
  output logic [C*K-1:0] delta_out,
  output logic [C-1:0]   valid_out,
  output logic [C-1:0]   err_out
);

  // The counter runs 0..STAGES+1 and then saturates. At saturation every
  // synchroniser stage holds post-reset data. tog_d and g_prev have also
  // had one cycle to follow the last stage.
  localparam int WARM_MAX = STAGES + 1;
  localparam int WARM_W   = $clog2(WARM_MAX + 1);

  logic [WARM_W-1:0] warm_cnt;
  logic              warm_done;

  assign warm_done = (warm_cnt == WARM_W'(WARM_MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warm_cnt <= '0;
    end else if (!warm_done) begin
      warm_cnt <= warm_cnt + WARM_W'(1);
    end
  end

  for (genvar c = 0; c < C; c++) begin : g_chan
    gray_cdc_chan #(
      .K      (K),
      .STAGES (STAGES)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .gray      (gray_in[c*K +: K]),
      .load      (load_in[c]),
      .warm_done (warm_done),
      .err_clr   (err_clr[c]),
      .bin       (bin_out[c*K +: K]),
      .delta     (delta_out[c*K +: K]),
      .valid     (valid_out[c]),
      .err       (err_out[c])
    );
  end

endmodule

// File: tb/tb_gray_cdc_rx.sv
// Directed testbench for gray_cdc_rx.
// The reference model works in terms of edges counted since reset release:
//   - the word and toggle seen at the end of the synchroniser before edge t
//     are the inputs sampled at edge t-STAGES;
//   - captures and error checks are allowed from edge STAGES+2 onward.
// Gray-to-binary conversion uses an inverted binary-to-Gray table.
// Multi-bit steps are found with a population count.
module tb_gray_cdc_rx;

  localparam int K      = 8;
  localparam int C      = 4;
  localparam int STAGES = 2;
  localparam int W      = C * K;
  localparam int HN     = 4096;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] gray_in = '0;
  logic [C-1:0] load_in = '0;
  logic [C-1:0] err_clr = '0;
  logic [W-1:0] bin_out;
  logic [W-1:0] delta_out;
  logic [C-1:0] valid_out;
  logic [C-1:0] err_out;

  gray_cdc_rx #(
    .K      (K),
    .C      (C),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gray_in   (gray_in),
    .load_in   (load_in),
    .err_clr   (err_clr),
    .bin_out   (bin_out),
    .delta_out (delta_out),
    .valid_out (valid_out),
    .err_out   (err_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [K-1:0] lane(input logic [W-1:0] v, input int c);
    return v[c*K +: K];
  endfunction

  // Inputs change 2 time units after the rising edge, well away from it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- reference model ----------------
  logic [K-1:0] bin_of_gray [2**K];
  logic [W-1:0] hist_g [HN];
  logic [C-1:0] hist_l [HN];
  int           t;
  logic [W-1:0] exp_bin, exp_delta;
  logic [C-1:0] exp_valid, exp_err;

  function automatic logic [W-1:0] g_at(input int k);
    return (k < 1) ? '0 : hist_g[k];
  endfunction

  function automatic logic [C-1:0] l_at(input int k);
    return (k < 1) ? '0 : hist_l[k];
  endfunction

  initial begin
    logic [K-1:0] bb;
    for (int b = 0; b < 2**K; b++) begin
      bb = K'(b);
      bin_of_gray[bb ^ (bb >> 1)] = bb;
    end
  end

  initial begin
    logic [W-1:0] gv_now, gv_old;
    logic [C-1:0] lv_now, lv_old;
    logic [K-1:0] g_now, g_old, b_new, b_old;
    bit           warm;
    t = 0;
    exp_bin = '0; exp_delta = '0; exp_valid = '0; exp_err = '0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        t = 0;
        exp_bin = '0; exp_delta = '0; exp_valid = '0; exp_err = '0;
      end else begin
        t++;
        if (t < HN) begin
          hist_g[t] = gray_in;
          hist_l[t] = load_in;
        end
        warm   = (t >= STAGES + 2);
        gv_now = g_at(t - STAGES);
        gv_old = g_at(t - STAGES - 1);
        lv_now = l_at(t - STAGES);
        lv_old = l_at(t - STAGES - 1);
        for (int c = 0; c < C; c++) begin
          g_now = gv_now[c*K +: K];
          g_old = gv_old[c*K +: K];
          exp_valid[c] = 1'b0;
          if (warm && (lv_now[c] != lv_old[c])) begin
            b_new = bin_of_gray[g_now];
            b_old = exp_bin[c*K +: K];
            exp_delta[c*K +: K] = b_new - b_old;
            exp_bin[c*K +: K]   = b_new;
            exp_valid[c]        = 1'b1;
          end
          if (warm && ($countones(g_now ^ g_old) >= 2)) exp_err[c] = 1'b1;
          else if (err_clr[c])                           exp_err[c] = 1'b0;
        end
      end
    end
  end

  // Compare process: checks all outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("cmp_valid", 64'(valid_out), 64'(exp_valid));
        check("cmp_bin",   64'(bin_out),   64'(exp_bin));
        check("cmp_delta", 64'(delta_out), 64'(exp_delta));
        check("cmp_err",   64'(err_out),   64'(exp_err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  task automatic toggle_observe(input int c, output int first, output int cnt);
    load_in[c] = ~load_in[c];
    first = -1;
    cnt   = 0;
    for (int i = 1; i <= STAGES + 4; i++) begin
      step();
      if (valid_out[c]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
  endtask

  initial begin
    int first, cnt, vcount;

    #3 rst = 1'b0;
    mon_en = 1'b1;
    gray_in[0 +: K] = 8'h0C;
    load_in[0]      = 1'b1;
    repeat (3) step();
    check("reset_bin",   64'(bin_out),   64'h0);
    check("reset_delta", 64'(delta_out), 64'h0);
    check("reset_valid", 64'(valid_out), 64'h0);
    check("reset_err",   64'(err_out),   64'h0);

    // Release with the toggle already high: it must be absorbed.
    @(posedge clk); #2 rst = 1'b1;
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (valid_out != '0) vcount++;
    end
    check("warmup_no_valid", 64'(vcount), 64'd0);
    check("warmup_err",      64'(err_out), 64'h0);

    // First capture: gray 0C -> binary 08, delta from 0.
    toggle_observe(0, first, cnt);
    check("cap0_latency", 64'(first), 64'(STAGES + 1));
    check("cap0_pulses",  64'(cnt),   64'd1);
    check("cap0_bin",     64'(lane(bin_out, 0)),   64'h08);
    check("cap0_delta",   64'(lane(delta_out, 0)), 64'h08);

    // Wrap: bin FE (gray 81), then gray 02 -> bin 03, delta 05.
    gray_in[0 +: K] = 8'h81;
    repeat (STAGES + 2) step();
    toggle_observe(0, first, cnt);
    check("wrap_a_bin",   64'(lane(bin_out, 0)),   64'hFE);
    check("wrap_a_delta", 64'(lane(delta_out, 0)), 64'hF6);
    gray_in[0 +: K] = 8'h02;
    repeat (STAGES + 2) step();
    toggle_observe(0, first, cnt);
    check("wrap_b_bin",   64'(lane(bin_out, 0)),   64'h03);
    check("wrap_b_delta", 64'(lane(delta_out, 0)), 64'h05);

    // Violation on ch2: 00 -> 03.
    gray_in[2*K +: K] = 8'h03;
    repeat (STAGES + 1) step();
    check("viol_set",  64'(err_out[2]), 64'd1);
    repeat (3) step();
    check("viol_held", 64'(err_out[2]), 64'd1);
    err_clr[2] = 1'b1;
    step();
    err_clr[2] = 1'b0;
    step();
    check("viol_clr", 64'(err_out[2]), 64'd0);
    // The clear lands on the same edge as a new violation (03 -> 00).
    gray_in[2*K +: K] = 8'h00;
    repeat (STAGES) step();
    err_clr[2] = 1'b1;
    step();
    err_clr[2] = 1'b0;
    check("viol_set_wins", 64'(err_out[2]), 64'd1);
    step();
    check("viol_set_wins_held", 64'(err_out[2]), 64'd1);

    // Simultaneous toggles on ch1 and ch3.
    gray_in[1*K +: K] = 8'h01;
    gray_in[3*K +: K] = 8'h02;
    repeat (STAGES + 2) step();
    load_in[1] = ~load_in[1];
    load_in[3] = ~load_in[3];
    repeat (STAGES + 1) step();
    check("dual_valid",  64'(valid_out), 64'b1010);
    check("dual_bin1",   64'(lane(bin_out, 1)),   64'h01);
    check("dual_delta1", 64'(lane(delta_out, 1)), 64'h01);
    check("dual_bin3",   64'(lane(bin_out, 3)),   64'h03);
    check("dual_delta3", 64'(lane(delta_out, 3)), 64'h03);
    check("dual_bin0",   64'(lane(bin_out, 0)),   64'h03);
    check("dual_bin2",   64'(lane(bin_out, 2)),   64'h00);
    step();
    check("dual_valid_end", 64'(valid_out), 64'b0000);

    // Back-to-back toggles on ch1: three consecutive pulses, delta 0.
    repeat (3) begin
      load_in[1] = ~load_in[1];
      step();
    end
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (valid_out[1]) vcount++;
      step();
    end
    check("b2b_pulses", 64'(vcount), 64'd3);
    check("b2b_delta",  64'(lane(delta_out, 1)), 64'h00);

    // Reset asserted one cycle before a pending capture.
    load_in[0] = ~load_in[0];
    repeat (STAGES) step();
    #1 rst = 1'b0;
    #1;
    check("async_bin",   64'(bin_out),   64'h0);
    check("async_delta", 64'(delta_out), 64'h0);
    check("async_valid", 64'(valid_out), 64'h0);
    check("async_err",   64'(err_out),   64'h0);
    @(posedge clk); #2 rst = 1'b1;
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (valid_out != '0) vcount++;
    end
    check("post_reset_no_valid", 64'(vcount), 64'd0);
    toggle_observe(0, first, cnt);
    check("post_reset_latency", 64'(first), 64'(STAGES + 1));
    check("post_reset_pulses",  64'(cnt),   64'd1);
    check("post_reset_bin",     64'(lane(bin_out, 0)),   64'h03);
    check("post_reset_delta",   64'(lane(delta_out, 0)), 64'h03);

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_cdc_rx.md
# gray_cdc_rx

Multi-channel receive-side endpoint for Gray-coded counters crossing into a single clock domain. Each of C channels synchronises a K-bit Gray word and a load toggle through a STAGES-deep flop chain. On each toggle edge it captures the word, converts it to binary, and reports the modulo-2^K delta from the previous capture. It sits directly behind free-running source-domain Gray counters and replaces a discrete synchroniser, load register and converter chain. It adds depth, channel count, delta output and Gray-violation detection.

## Interface
- K, 8, counter width per channel (≥2)
- C, 4, channel count (≥1)
- STAGES, 2, synchroniser depth (≥2)
- clk  in  1  receive-domain clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- gray_in  in  C*K  asynchronous Gray words, channel c at [c*K +: K]
- load_in  in  C  asynchronous load toggles, one per channel; each level change = new word
- err_clr  in  C  synchronous per-channel clear of err_out
- bin_out  out  C*K  last captured value, binary
- delta_out  out  C*K  bin_out minus previous bin_out, modulo 2^K
- valid_out  out  C  one-cycle pulse per capture
- err_out  out  C  sticky Gray-violation flag

## Operation
- Per channel, gray_in and load_in pass through STAGES flops: s_gray and s_tog at the last stage.
- tog_d registers s_tog every cycle. A change is detected when s_tog != tog_d.
- Warm-up counter:
  - Counts 0..STAGES+1 after reset release, then saturates. It is shared by all channels.
  - While it is unsaturated: no capture, no error check, tog_d and g_prev still track.
- Capture on a change:
  - bin_out <= g2b(s_gray).
  - delta_out <= g2b(s_gray) - bin_out, K-bit wrap.
  - valid_out <= 1.
  - Otherwise valid_out <= 0 and the other outputs hold.
- g2b: bit K-1 passes through; bit i = XOR of gray bits K-1..i.
- Error check:
  - g_prev registers s_gray every cycle.
  - After warm-up, if s_gray ^ g_prev has ≥2 bits set, err_out <= 1.
  - err_clr clears the flag. Set wins over a simultaneous clear.
- Channels are fully independent except for the shared warm-up counter.

## Timing
- Reset (rst low): all flops clear immediately, including synchronisers, tog_d, g_prev and warm-up. All outputs are 0.
- Latency: a load_in level change sampled at edge n produces a change-detect after edge n+STAGES-1. valid_out, bin_out and delta_out update at edge n+STAGES and are visible the following cycle.
- gray_in must be stable ≥STAGES+1 cycles before the load_in toggle. This is the source-side contract and is not checked.
- Back-to-back toggles, one per cycle at s_tog: each produces its own valid pulse, so valid_out can stay high continuously.
- First capture after reset: delta_out = bin_out, since the previous value is 0.
- Toggle pending at reset assertion: it is discarded. No valid_out appears after release until a fresh toggle arrives post warm-up.
- Source toggle already at 1 when reset releases: it is absorbed during warm-up and produces no valid.

## Structure
- Package gray_cdc_pkg holds:
  - function g2b(K-bit).
  - function multi_bit(K-bit xor) → 1 if ≥2 bits set.
  - Default constants for K, C and STAGES.
- Sub-module gray_cdc_chan:
  - One channel: synchroniser, toggle detect, capture, delta and error flag.
  - Instantiated C times in a generate loop.
  - It takes the warm-up-done bit as an input. The top holds only the warm-up counter and port slicing.

## Test plan
- Reset release with ch0 gray_in=8'h0C and load_in[0]=1 -> no valid_out and err_out=0 over 10 cycles; all outputs 0 during reset.
- After warm-up, ch0 gray_in=8'h0C, then load_in[0] toggles -> valid_out[0] high for exactly one cycle, STAGES+1 edges later; bin_out=8'h08, delta_out=8'h08.
- Wrap: previous bin_out=8'hFE, then gray 8'h02 plus toggle -> bin_out=8'h03, delta_out=8'h05.
- Violation: ch2 gray steps 8'h00->8'h03 -> err_out[2]=1 within STAGES+1 cycles and held. err_clr[2] clears it. err_clr concurrent with a new violation -> stays 1.
- Toggle ch1 and ch3 in the same cycle -> both valid_out bits pulse in the same cycle; ch0 and ch2 outputs unchanged.
- Assert rst one cycle before a pending capture -> outputs 0 asynchronously. After release, no valid_out until a new toggle arrives post warm-up.
